// File: rtl/soc_pkg.sv
// Shared opcode encodings, FSM state constants and the opcode-to-channel
// steering function used by the merge_n request merger.
package soc_pkg;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OP_R_TYPE    = 7'b0110011;
    localparam opcode_t OP_I_TYPE_OP = 7'b0010011;
    localparam opcode_t OP_I_TYPE_LD = 7'b0000011;
    localparam opcode_t OP_S_TYPE    = 7'b0100011;
    localparam opcode_t OP_B_TYPE    = 7'b1100011;
    localparam opcode_t OP_J_TYPE    = 7'b1101111;
    // NOP is addi x0,x0,0 and therefore shares the I_type_op encoding.
    localparam opcode_t OP_NOP       = 7'b0010011;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_ACK  = 2'd2;
    localparam state_t ST_REL  = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [1:0] ch;
    } op_map_t;

    function automatic op_map_t opcode_to_ch(input opcode_t op);
        op_map_t m;
        m.valid = 1'b1;
        m.ch    = 2'd2;
        case (op)
            OP_B_TYPE, OP_J_TYPE:                  m.ch = 2'd0;
            OP_S_TYPE:                             m.ch = 2'd1;
            OP_R_TYPE, OP_I_TYPE_OP, OP_I_TYPE_LD: m.ch = 2'd2;
            default: begin
                m.valid = 1'b0;
                m.ch    = 2'd0;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/merge_n_if.sv
// Handshake bundle between N_CH upstream 4-phase requesters, the merger
// and the single downstream 4-phase responder.
interface merge_n_if
    import soc_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
);
    opcode_t         opcode;
    logic [N_CH-1:0] req_in;
    logic            ack_in;
    logic            req_out;
    logic [N_CH-1:0] ack_out;
    logic [IW-1:0]   grant_idx;
    logic            err;

    modport master (
        output opcode, req_in, ack_in,
        input  req_out, ack_out, grant_idx, err
    );

    modport slave (
        input  opcode, req_in, ack_in,
        output req_out, ack_out, grant_idx, err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above i_ptr,
// wrapping modulo N_CH.
module rr_arbiter #(
    parameter int N_CH = 3,
    parameter int IW   = 2
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx
);

    logic [2*N_CH-1:0] w_dbl;
    logic [N_CH-1:0]   w_rot;
    logic [IW-1:0]     w_off;
    logic [IW:0]       w_sum;

    // Rotating a doubled copy puts channel (ptr+k) mod N_CH at bit k.
    assign w_dbl = {i_req, i_req};
    assign w_rot = N_CH'(w_dbl >> i_ptr);

    always_comb begin
        o_valid = 1'b0;
        w_off   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_valid = 1'b1;
                w_off   = IW'(k);
            end
        end
    end

    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx = (w_sum >= (IW+1)'(N_CH)) ? IW'(w_sum - (IW+1)'(N_CH))
                                            : w_sum[IW-1:0];

endmodule

// File: rtl/merge_n.sv
// N-to-1 4-phase request merger with opcode-steered or round-robin selection;
// every output is a register.
module merge_n
    import soc_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int MODE = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    merge_n_if.slave  bus
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t          r_state;
    logic            r_reqOut;
    logic [N_CH-1:0] r_ackOut;
    logic [IW-1:0]   r_grant;
    logic [IW-1:0]   r_rrPtr;
    logic            r_err;
    logic            r_errDone;
    opcode_t         r_prevOp;

    op_map_t         w_map;
    logic [3:0]      w_reqPad;
    logic            w_m0Valid;
    logic            w_rrValid;
    logic [IW-1:0]   w_rrIdx;
    logic            w_candValid;
    logic [IW-1:0]   w_candIdx;
    logic [IW-1:0]   w_nextPtr;
    logic            w_illegal;
    logic            w_opChanged;
    logic            w_errFire;

    // Opcode steering only reaches channels 0..2, and only those that exist.
    assign w_map     = opcode_to_ch(bus.opcode);
    assign w_reqPad  = 4'(bus.req_in);
    assign w_m0Valid = w_map.valid && (int'(w_map.ch) < N_CH) && w_reqPad[w_map.ch];

    rr_arbiter #(
        .N_CH (N_CH),
        .IW   (IW)
    ) u_rrArbiter (
        .i_req   (bus.req_in),
        .i_ptr   (r_rrPtr),
        .o_valid (w_rrValid),
        .o_idx   (w_rrIdx)
    );

    always_comb begin
        w_candValid = 1'b0;
        w_candIdx   = '0;
        if (MODE == 0) begin
            w_candValid = w_m0Valid;
            w_candIdx   = IW'(w_map.ch);
        end else begin
            w_candValid = w_rrValid;
            w_candIdx   = w_rrIdx;
        end
    end

    assign w_nextPtr = (w_candIdx == IW'(N_CH - 1)) ? '0 : w_candIdx + 1'b1;

    // err fires once per distinct illegal opcode seen in IDLE with a request pending.
    assign w_illegal   = (MODE == 0) && !w_map.valid && (|bus.req_in);
    assign w_opChanged = (bus.opcode != r_prevOp);
    assign w_errFire   = (r_state == ST_IDLE) && w_illegal && (w_opChanged || !r_errDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_reqOut  <= 1'b0;
            r_ackOut  <= '0;
            r_grant   <= '0;
            r_rrPtr   <= '0;
            r_err     <= 1'b0;
            r_errDone <= 1'b0;
            r_prevOp  <= '0;
        end else begin
            r_err    <= w_errFire;
            r_prevOp <= bus.opcode;
            if (w_errFire) begin
                r_errDone <= 1'b1;
            end else if (w_opChanged) begin
                r_errDone <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_candValid && !bus.ack_in) begin
                        r_state  <= ST_REQ;
                        r_reqOut <= 1'b1;
                        r_grant  <= w_candIdx;
                        r_rrPtr  <= w_nextPtr;
                    end
                end
                ST_REQ: begin
                    if (bus.ack_in) begin
                        r_state  <= ST_ACK;
                        r_ackOut <= N_CH'(1) << r_grant;
                    end
                end
                ST_ACK: begin
                    if (!bus.req_in[r_grant]) begin
                        r_state  <= ST_REL;
                        r_reqOut <= 1'b0;
                    end
                end
                ST_REL: begin
                    if (!bus.ack_in) begin
                        r_state  <= ST_IDLE;
                        r_ackOut <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_out   = r_reqOut;
    assign bus.ack_out   = r_ackOut;
    assign bus.grant_idx = r_grant;
    assign bus.err       = r_err;

endmodule
